nonconsec_pulse_gen: RTL and testbench

- Stimulus generator for the non-consecutive-repetition handshake: opening strobe on b_out, then N single-cycle a_out pulses separated by idle gaps, then a closing strobe on b_out.
- Sits in the sim/SVA area as the driver side of the `$rose(b) |-> a[=N] ##1 b` checkers.
- Replaces hand-written `#delay` stimulus tasks with a cycle-exact, programmable RTL source.

---
 rtl/nonconsec_pulse_gen_pkg.sv | 26 ++
 rtl/nonconsec_pulse_gen_if.sv | 30 +++
 rtl/nonconsec_pulse_gen_gap_timer.sv | 32 +++
 rtl/nonconsec_pulse_gen.sv | 106 ++++++++++
 tb/tb_nonconsec_pulse_gen.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/nonconsec_pulse_gen_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nonconsec_pkg : shared types for the non-consecutive pulse generator  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package nonconsec_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    LEAD  = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4,
    TAIL  = 3'd5,
    CLOSE = 3'd6
  } state_t;

  // Substituted for a requested gap of zero so a_out can never repeat back to back.
  localparam int DEFAULT_GAP = 1;

  function automatic logic is_wait_state(input state_t s);
    return (s == LEAD) || (s == GAP) || (s == TAIL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nonconsec_pulse_gen_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nonconsec_pulse_gen_if : control/strobe bundle of the pulse generator |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface nonconsec_pulse_gen_if #(
  parameter int CNT_W = 2,
  parameter int GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] num_pulses;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             b_out;
  logic             a_out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, num_pulses, gap, abort,
    input  b_out, a_out, busy, done, err
  );

  modport slave (
    input  start, num_pulses, gap, abort,
    output b_out, a_out, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/nonconsec_pulse_gen_gap_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gap_timer : down-counter timing the idle stretches of a burst         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module gap_timer #(
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] g_r,
  output logic             expire
);

  logic [GAP_W-1:0] cnt_r;

  // Loading g_r-1 makes expire assert in the g_r-th cycle of the wait state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= g_r - GAP_W'(1);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - GAP_W'(1);
    end
  end

  assign expire = (cnt_r == '0);

endmodule
`default_nettype wire

// File: rtl/nonconsec_pulse_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nonconsec_pulse_gen : b strobe, N spaced a pulses, closing b strobe   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module nonconsec_pulse_gen
  import nonconsec_pkg::*;
#(
  parameter int MAX_PULSES = 3,
  parameter int CNT_W      = 2,
  parameter int GAP_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nonconsec_pulse_gen_if.slave bus
);

  localparam logic [CNT_W:0] MAX_N = (CNT_W+1)'(MAX_PULSES);

  state_t           state_r;
  state_t           state_nxt;
  logic [CNT_W-1:0] n_r;
  logic [GAP_W-1:0] g_r;
  logic [CNT_W-1:0] pcnt_r;
  logic             done_r;
  logic             err_r;

  logic             start_idle;
  logic             n_legal;
  logic             accept;
  logic             reject;
  logic [CNT_W:0]   pcnt_inc;
  logic             last_pulse;
  logic             timer_load;
  logic             timer_expire;

  assign start_idle = (state_r == IDLE) && bus.start;
  assign n_legal    = (bus.num_pulses != '0) && ({1'b0, bus.num_pulses} <= MAX_N);
  assign accept     = start_idle && n_legal;
  assign reject     = start_idle && !n_legal;

  // Widened so the final increment cannot wrap before the compare.
  assign pcnt_inc   = {1'b0, pcnt_r} + (CNT_W+1)'(1);
  assign last_pulse = (pcnt_inc == {1'b0, n_r});

  assign timer_load = is_wait_state(state_nxt) && (state_nxt != state_r);

  gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .g_r    (g_r),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      n_r     <= '0;
      g_r     <= '0;
      pcnt_r  <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      done_r  <= (state_r == CLOSE) && !bus.abort;
      err_r   <= reject;
      if (accept) begin
        n_r    <= bus.num_pulses;
        g_r    <= (bus.gap == '0) ? GAP_W'(DEFAULT_GAP) : bus.gap;
        pcnt_r <= '0;
      end else if (state_r == PULSE) begin
        pcnt_r <= pcnt_inc[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state_r;
    if ((state_r != IDLE) && bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state_r)
        IDLE:      if (accept) state_nxt = OPEN;
        OPEN:      state_nxt = LEAD;
        LEAD, GAP: if (timer_expire) state_nxt = PULSE;
        PULSE:     state_nxt = last_pulse ? TAIL : GAP;
        TAIL:      if (timer_expire) state_nxt = CLOSE;
        CLOSE:     state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.b_out = (state_r == OPEN) || (state_r == CLOSE);
    bus.a_out = (state_r == PULSE);
    bus.busy  = (state_r != IDLE);
    bus.done  = done_r;
    bus.err   = err_r;
  end

endmodule
`default_nettype wire

// File: tb/tb_nonconsec_pulse_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_nonconsec_pulse_gen : scoreboard bench against a timing model      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_nonconsec_pulse_gen;

  localparam int MAX_PULSES = 3;
  localparam int CNT_W      = 2;
  localparam int GAP_W      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nonconsec_pulse_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) ifc ();
  nonconsec_pulse_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) ifc2 ();

  nonconsec_pulse_gen #(
    .MAX_PULSES (MAX_PULSES),
    .CNT_W      (CNT_W),
    .GAP_W      (GAP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Second instance with a smaller limit to exercise the upper reject bound.
  nonconsec_pulse_gen #(
    .MAX_PULSES (2),
    .CNT_W      (CNT_W),
    .GAP_W      (GAP_W)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (ifc2.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  // Burst timeline from the accept cycle k: b at k+1, pulse j at k+1+j*(G+1),
  // closing b at k+2+N+(N+1)*G, done one cycle later.
  function automatic logic [4:0] expect_at(input int c, input bit act, input int k,
                                           input int n, input int g, input bit e);
    int  o;
    int  close_c;
    logic b, a, bsy, dn;
    o       = c - k;
    close_c = k + 2 + n + (n + 1) * g;
    b   = act && ((o == 1) || (c == close_c));
    a   = act && (o >= 2) && (((o - 1) % (g + 1)) == 0) && (((o - 1) / (g + 1)) <= n);
    bsy = act && (o >= 1) && (c <= close_c);
    dn  = act && (c == close_c + 1);
    return {b, a, bsy, dn, e};
  endfunction

  int cyc    = 0;
  bit active = 1'b0;
  int k_m    = 0;
  int n_m    = 0;
  int g_m    = 0;

  always @(posedge clk) begin
    int close_c;
    bit idle_prev;
    bit err_e;
    cyc++;
    close_c   = k_m + 2 + n_m + (n_m + 1) * g_m;
    idle_prev = !active || ((cyc - 1) > close_c);
    err_e     = 1'b0;
    if (rst) begin
      active = 1'b0;
    end else if (!idle_prev && ifc.abort) begin
      active = 1'b0;
    end else if (idle_prev && ifc.start) begin
      if (int'(ifc.num_pulses) >= 1 && int'(ifc.num_pulses) <= MAX_PULSES) begin
        active = 1'b1;
        k_m    = cyc - 1;
        n_m    = int'(ifc.num_pulses);
        g_m    = (ifc.gap == '0) ? 1 : int'(ifc.gap);
      end else begin
        err_e = 1'b1;
      end
    end
    exp_q.push_back(expect_at(cyc, active, k_m, n_m, g_m, err_e));
  end

  logic prev_a = 1'b0;

  always @(negedge clk) begin
    logic [4:0] act_v;
    logic [4:0] exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {ifc.b_out, ifc.a_out, ifc.busy, ifc.done, ifc.err};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t {b,a,busy,done,err} got %b expected %b", $time, act_v, exp_v);
      end
      checks++;
      if (prev_a && ifc.a_out) begin
        errors++;
        $display("FAIL a_consec t=%0t a_out got 1 in consecutive cycles, expected 0", $time);
      end
      checks++;
      if (ifc.a_out && ifc.b_out) begin
        errors++;
        $display("FAIL a_b_onehot t=%0t a_out=%b b_out=%b expected not both", $time, ifc.a_out, ifc.b_out);
      end
      prev_a = ifc.a_out;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input bit s, input int n, input int g, input bit ab, input bit r);
    ifc.start      = s;
    ifc.num_pulses = CNT_W'(n);
    ifc.gap        = GAP_W'(g);
    ifc.abort      = ab;
    rst            = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int c);
    repeat (c) step(0, 0, 0, 0, 0);
  endtask

  task automatic step2(input bit s, input int n, input bit ab);
    ifc2.start      = s;
    ifc2.num_pulses = CNT_W'(n);
    ifc2.gap        = GAP_W'(1);
    ifc2.abort      = ab;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifc.start = 1'b0; ifc.num_pulses = '0; ifc.gap = '0; ifc.abort = 1'b0;
    ifc2.start = 1'b0; ifc2.num_pulses = '0; ifc2.gap = '0; ifc2.abort = 1'b0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle(2);

    step(1, 2, 1, 0, 0); idle(10);           // N=2 G=1
    step(1, 3, 2, 0, 0); idle(16);           // N=3 G=2
    step(1, 2, 0, 0, 0); idle(10);           // gap=0 clamps to 1
    step(1, 0, 3, 0, 0); idle(3);            // N=0 rejected
    step(1, 3, 2, 0, 0); idle(3);            // abort at cycle 4
    step(0, 0, 0, 1, 0); idle(1);
    step(1, 1, 1, 0, 0); idle(8);
    step(1, 3, 15, 0, 0); idle(70);          // maximum gap
    step(1, 2, 3, 0, 0); step(1, 2, 3, 1, 1) ; // start+abort+rst together while busy
    idle(2);
    step(1, 1, 1, 1, 0); idle(6);            // start+abort in IDLE: start wins
    repeat (6) step(1, 2, 3, 0, 0);          // start held, rst mid-GAP
    step(1, 2, 3, 0, 1);
    repeat (20) step(1, 2, 3, 0, 0);
    idle(20);

    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 3) == 0,
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3)),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 199) == 0);
    end
    idle(80);

    step2(1, 3, 0);
    ifc2.start = 1'b0;
    check("dut2_err_n3", ifc2.err, 1'b1);
    check("dut2_b_n3", ifc2.b_out, 1'b0);
    check("dut2_busy_n3", ifc2.busy, 1'b0);
    step2(0, 0, 0);
    check("dut2_err_pulse_len", ifc2.err, 1'b0);
    check("dut2_busy_after_err", ifc2.busy, 1'b0);
    step2(1, 0, 0);
    check("dut2_err_n0", ifc2.err, 1'b1);
    check("dut2_b_n0", ifc2.b_out, 1'b0);
    step2(1, 2, 0);
    check("dut2_accept_b", ifc2.b_out, 1'b1);
    check("dut2_accept_busy", ifc2.busy, 1'b1);
    check("dut2_accept_err", ifc2.err, 1'b0);
    step2(0, 0, 1);
    check("dut2_abort_busy", ifc2.busy, 1'b0);
    step2(0, 0, 0);
    check("dut2_abort_done", ifc2.done, 1'b0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
